// File: rtl/mem_bank_1rw_arb.sv
// Arbiter/sequencer sharing one 1RW register-file bank between two requesters.
// Define MEM_BANK_ARB_RR_EN for round-robin; default build is fixed priority (port 0 wins).
module mem_bank_1rw_arb #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             p0_req_valid,
    output logic             p0_req_ready,
    input  logic             p0_req_wen,
    input  logic [AW-1:0]    p0_req_addr,
    input  logic [WIDTH-1:0] p0_req_wmask,
    input  logic [WIDTH-1:0] p0_req_wdata,
    output logic             p0_resp_valid,
    input  logic             p0_resp_ready,
    output logic [WIDTH-1:0] p0_resp_rdata,

    input  logic             p1_req_valid,
    output logic             p1_req_ready,
    input  logic             p1_req_wen,
    input  logic [AW-1:0]    p1_req_addr,
    input  logic [WIDTH-1:0] p1_req_wmask,
    input  logic [WIDTH-1:0] p1_req_wdata,
    output logic             p1_resp_valid,
    input  logic             p1_resp_ready,
    output logic [WIDTH-1:0] p1_resp_rdata,

    output logic             mem_wen,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_wmask,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

    logic [1:0]       req_valid;
    logic [1:0]       req_wen;
    logic [1:0]       resp_ready;
    logic [1:0]       resp_valid;
    logic [1:0]       elig;
    logic [1:0]       gnt;
    logic [1:0]       rd_gnt;
    logic [WIDTH-1:0] resp_rdata [2];

    logic             last_grant_q;
    logic             last_grant_d;

    assign req_valid  = {p1_req_valid, p0_req_valid};
    assign req_wen    = {p1_req_wen, p0_req_wen};
    assign resp_ready = {p1_resp_ready, p0_resp_ready};

    for (genvar p = 0; p < 2; p++) begin : g_port
        slot_e            slot_q;
        slot_e            slot_d;
        logic [WIDTH-1:0] rdata_q;
        logic [WIDTH-1:0] rdata_d;

        assign resp_valid[p] = (slot_q == SLOT_FULL);
        assign resp_rdata[p] = rdata_q;
        // Writes never occupy the slot, so only reads wait for it to drain.
        assign elig[p]   = !reset && req_valid[p] &&
                           (req_wen[p] || !resp_valid[p] || resp_ready[p]);
        assign rd_gnt[p] = gnt[p] && !req_wen[p];

        always_comb begin
            slot_d  = slot_q;
            rdata_d = rdata_q;
            if (rd_gnt[p]) begin
                slot_d  = SLOT_FULL;
                rdata_d = mem_rdata;
            end else if (resp_valid[p] && resp_ready[p]) begin
                slot_d = SLOT_EMPTY;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                slot_q  <= SLOT_EMPTY;
                rdata_q <= '0;
            end else begin
                slot_q  <= slot_d;
                rdata_q <= rdata_d;
            end
        end
    end

    always_comb begin
        gnt = '0;
`ifdef MEM_BANK_ARB_RR_EN
        if (elig == 2'b11) begin
            gnt = last_grant_q ? 2'b01 : 2'b10;
        end else begin
            gnt = elig;
        end
`else
        if (elig[0]) begin
            gnt = 2'b01;
        end else begin
            gnt = elig;
        end
`endif
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (gnt[1]) begin
            last_grant_d = 1'b1;
        end else if (gnt[0]) begin
            last_grant_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wmask = '0;
        mem_wdata = '0;
        if (gnt[0]) begin
            mem_wen   = p0_req_wen;
            mem_addr  = p0_req_addr;
            mem_wmask = p0_req_wmask;
            mem_wdata = p0_req_wdata;
        end else if (gnt[1]) begin
            mem_wen   = p1_req_wen;
            mem_addr  = p1_req_addr;
            mem_wmask = p1_req_wmask;
            mem_wdata = p1_req_wdata;
        end
    end

    assign p0_req_ready  = gnt[0];
    assign p1_req_ready  = gnt[1];
    assign p0_resp_valid = resp_valid[0];
    assign p1_resp_valid = resp_valid[1];
    assign p0_resp_rdata = resp_rdata[0];
    assign p1_resp_rdata = resp_rdata[1];

endmodule

// File: tb/tb_mem_bank_1rw_arb.sv
// Scoreboard bench for mem_bank_1rw_arb: directed requests push expected read data,
// an independent monitor pops and compares on every response handshake.
module tb_mem_bank_1rw_arb;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned AW    = 2;

    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] D_A    = 64'hAAAA_5555_0F0F_F0F0;
    localparam logic [63:0] D_M    = 64'hFFFF_FFFF_0000_FFFF;
    localparam logic [63:0] D_C    = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D_5A   = 64'h5A5A_5A5A_5A5A_5A5A;
    localparam logic [63:0] D_1234 = 64'h0000_0000_0000_1234;
    localparam logic [63:0] MASK_M = 64'h0000_0000_FFFF_0000;

    logic             clk = 1'b0;
    logic             reset;
    logic             p0_req_valid, p0_req_ready, p0_req_wen;
    logic [AW-1:0]    p0_req_addr;
    logic [WIDTH-1:0] p0_req_wmask, p0_req_wdata;
    logic             p0_resp_valid, p0_resp_ready;
    logic [WIDTH-1:0] p0_resp_rdata;
    logic             p1_req_valid, p1_req_ready, p1_req_wen;
    logic [AW-1:0]    p1_req_addr;
    logic [WIDTH-1:0] p1_req_wmask, p1_req_wdata;
    logic             p1_resp_valid, p1_resp_ready;
    logic [WIDTH-1:0] p1_resp_rdata;
    logic             mem_wen;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wmask, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q0 [$];
    logic [63:0] exp_q1 [$];
    logic [1:0]  prev_rd = 2'b00;

    always #5 clk = ~clk;

    mem_bank_1rw_arb #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_wen(p0_req_wen),
        .p0_req_addr(p0_req_addr), .p0_req_wmask(p0_req_wmask), .p0_req_wdata(p0_req_wdata),
        .p0_resp_valid(p0_resp_valid), .p0_resp_ready(p0_resp_ready), .p0_resp_rdata(p0_resp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_wen(p1_req_wen),
        .p1_req_addr(p1_req_addr), .p1_req_wmask(p1_req_wmask), .p1_req_wdata(p1_req_wdata),
        .p1_resp_valid(p1_resp_valid), .p1_resp_ready(p1_resp_ready), .p1_resp_rdata(p1_resp_rdata),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Register-file bank: combinational read, masked write, cleared by the shared reset.
    logic [WIDTH-1:0] bank [DEPTH];
    assign mem_rdata = bank[mem_addr];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) bank[i] <= '0;
        end else if (mem_wen) begin
            bank[mem_addr] <= (bank[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
        end
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (p0_resp_valid && p0_resp_ready) begin
                if (exp_q0.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL p0 unexpected response: got %h expected none", p0_resp_rdata);
                end else begin
                    check("p0 rdata", p0_resp_rdata, exp_q0.pop_front());
                end
            end
            if (p1_resp_valid && p1_resp_ready) begin
                if (exp_q1.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL p1 unexpected response: got %h expected none", p1_resp_rdata);
                end else begin
                    check("p1 rdata", p1_resp_rdata, exp_q1.pop_front());
                end
            end
        end
    end

    // One clock of stimulus; grants are sampled at the falling edge and read grants queue e0/e1.
    task automatic cyc(input logic v0, input logic w0, input logic [AW-1:0] a0,
                       input logic [63:0] m0, input logic [63:0] d0, input logic [63:0] e0,
                       input logic v1, input logic w1, input logic [AW-1:0] a1,
                       input logic [63:0] m1, input logic [63:0] d1, input logic [63:0] e1,
                       output logic g0, output logic g1);
        p0_req_valid = v0; p0_req_wen = w0; p0_req_addr = a0; p0_req_wmask = m0; p0_req_wdata = d0;
        p1_req_valid = v1; p1_req_wen = w1; p1_req_addr = a1; p1_req_wmask = m1; p1_req_wdata = d1;
        @(negedge clk);
        if (prev_rd[0]) check("p0 read latency", 64'(p0_resp_valid), 64'd1);
        if (prev_rd[1]) check("p1 read latency", 64'(p1_resp_valid), 64'd1);
        g0 = p0_req_ready;
        g1 = p1_req_ready;
        prev_rd = {g1 && !w1, g0 && !w0};
        if (g0 && !w0) exp_q0.push_back(e0);
        if (g1 && !w1) exp_q1.push_back(e1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        logic g0, g1;
        cyc(0, 0, 0, '0, '0, '0, 0, 0, 0, '0, '0, '0, g0, g1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic g0, g1, done0, done1, first;

        reset = 1'b1;
        p0_resp_ready = 1'b1; p1_resp_ready = 1'b1;
        p0_req_valid = 1'b1; p0_req_wen = 1'b1; p0_req_addr = 2'd1; p0_req_wmask = ONES; p0_req_wdata = ONES;
        p1_req_valid = 1'b1; p1_req_wen = 1'b0; p1_req_addr = 2'd0; p1_req_wmask = '0; p1_req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset p0_req_ready", 64'(p0_req_ready), 64'd0);
        check("reset p1_req_ready", 64'(p1_req_ready), 64'd0);
        check("reset mem_wen", 64'(mem_wen), 64'd0);
        check("reset p0_resp_valid", 64'(p0_resp_valid), 64'd0);
        check("reset p1_resp_valid", 64'(p1_resp_valid), 64'd0);
        check("reset p0_resp_rdata", p0_resp_rdata, 64'd0);
        check("reset p1_resp_rdata", p1_resp_rdata, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Full write then read back on p0.
        cyc(1, 1, 2'd2, ONES, D_A, '0, 0, 0, 0, '0, '0, '0, g0, g1);
        check("p0 write grant", 64'(g0), 64'd1);
        cyc(1, 0, 2'd2, '0, '0, D_A, 0, 0, 0, '0, '0, '0, g0, g1);
        check("p0 read grant", 64'(g0), 64'd1);
        idle();

        // Masked write over an all-ones entry.
        cyc(1, 1, 2'd1, ONES, ONES, '0, 0, 0, 0, '0, '0, '0, g0, g1);
        cyc(1, 1, 2'd1, MASK_M, '0, '0, 0, 0, 0, '0, '0, '0, g0, g1);
        check("masked write grant", 64'(g0), 64'd1);
        cyc(1, 0, 2'd1, '0, '0, D_M, 0, 0, 0, '0, '0, '0, g0, g1);
        idle();

        // p1 write leaves last_grant at 1 ahead of the contention run.
        cyc(0, 0, 0, '0, '0, '0, 1, 1, 2'd0, ONES, D_C, '0, g0, g1);
        check("p1 write grant", 64'(g1), 64'd1);
        idle();

        for (int i = 0; i < 6; i++) begin
            logic exp0;
`ifdef MEM_BANK_ARB_RR_EN
            exp0 = (i % 2 == 0);
`else
            exp0 = 1'b1;
`endif
            cyc(1, 0, 2'd2, '0, '0, D_A, 1, 0, 2'd0, '0, '0, D_C, g0, g1);
            check("contention p0 grant", 64'(g0), 64'(exp0));
            check("contention p1 grant", 64'(g1), 64'(!exp0));
        end
        idle();

        // Backpressure on p0's response slot.
        p0_resp_ready = 1'b0;
        cyc(1, 0, 2'd2, '0, '0, D_A, 0, 0, 0, '0, '0, '0, g0, g1);
        check("bp p0 first read grant", 64'(g0), 64'd1);
        check("bp p0 resp_valid", 64'(p0_resp_valid), 64'd1);
        check("bp p0 rdata", p0_resp_rdata, D_A);
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 2'd1, '0, '0, D_M, 1, 0, 2'd0, '0, '0, D_C, g0, g1);
            check("bp p0 read blocked", 64'(g0), 64'd0);
            check("bp p1 read proceeds", 64'(g1), 64'd1);
            check("bp p0 resp held", 64'(p0_resp_valid), 64'd1);
            check("bp p0 rdata stable", p0_resp_rdata, D_A);
        end
        cyc(1, 1, 2'd3, ONES, D_5A, '0, 1, 0, 2'd0, '0, '0, D_C, g0, g1);
        check("bp p0 write granted", 64'(g0), 64'd1);
        check("bp p1 loses to write", 64'(g1), 64'd0);
        check("bp p0 rdata stable", p0_resp_rdata, D_A);
        p0_resp_ready = 1'b1;
        cyc(1, 0, 2'd1, '0, '0, D_M, 0, 0, 0, '0, '0, '0, g0, g1);
        check("bp release p0 read grant", 64'(g0), 64'd1);
        idle();

        // p1 write vs p0 read of the same address in the same cycle.
        done0 = 1'b0; done1 = 1'b0; first = 1'b1;
        for (int i = 0; i < 4 && !(done0 && done1); i++) begin
            cyc(!done0, 0, 2'd3, '0, '0, done1 ? D_1234 : D_5A,
                !done1, 1, 2'd3, ONES, D_1234, '0, g0, g1);
            if (first) begin
`ifdef MEM_BANK_ARB_RR_EN
                check("write-vs-read p1 wins", 64'(g1), 64'd1);
`else
                check("write-vs-read p0 wins", 64'(g0), 64'd1);
`endif
                first = 1'b0;
            end
            done0 = done0 | g0;
            done1 = done1 | g1;
        end
        check("write-vs-read both granted", 64'({done0, done1}), 64'd3);
        cyc(1, 0, 2'd3, '0, '0, D_1234, 0, 0, 0, '0, '0, '0, g0, g1);
        idle();

        // Fill both slots, then reset mid-operation.
        p0_resp_ready = 1'b0; p1_resp_ready = 1'b0;
        cyc(1, 0, 2'd2, '0, '0, D_A, 0, 0, 0, '0, '0, '0, g0, g1);
        cyc(0, 0, 0, '0, '0, '0, 1, 0, 2'd1, '0, '0, D_M, g0, g1);
        check("fill p1 read grant", 64'(g1), 64'd1);
        check("fill p0 full", 64'(p0_resp_valid), 64'd1);
        check("fill p1 full", 64'(p1_resp_valid), 64'd1);
        reset = 1'b1;
        p0_req_valid = 1'b0; p1_req_valid = 1'b0;
        exp_q0.delete(); exp_q1.delete();
        prev_rd = 2'b00;
        @(posedge clk);
        #1;
        check("midreset p0_resp_valid", 64'(p0_resp_valid), 64'd0);
        check("midreset p1_resp_valid", 64'(p1_resp_valid), 64'd0);
        check("midreset p0_resp_rdata", p0_resp_rdata, 64'd0);
        reset = 1'b0;
        p0_resp_ready = 1'b1; p1_resp_ready = 1'b1;
        cyc(1, 0, 2'd2, '0, '0, '0, 1, 0, 2'd2, '0, '0, '0, g0, g1);
        check("post-reset contention p0", 64'(g0), 64'd1);
        check("post-reset contention p1", 64'(g1), 64'd0);
        cyc(0, 0, 0, '0, '0, '0, 1, 0, 2'd3, '0, '0, '0, g0, g1);
        check("post-reset p1 grant", 64'(g1), 64'd1);
        cyc(1, 0, 2'd1, '0, '0, '0, 0, 0, 0, '0, '0, '0, g0, g1);
        repeat (3) idle();

        check("p0 scoreboard drained", 64'(exp_q0.size()), 64'd0);
        check("p1 scoreboard drained", 64'(exp_q1.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
